// File: rtl/wb_trace_buffer.sv
// ============================================================================
// Module      : wb_trace_buffer
// Description : Write-back trace FIFO. Captures {seq, inst, reg, data} records,
//               drains over valid/ready and flags a programmable result value.
//               Optional macro WB_TRACE_XZR_FILTER_EN ignores writes to reg 31.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_trace_buffer #(
    parameter int WORD      = 64,
    parameter int INST_SIZE = 32,
    parameter int REG_W     = 5,
    parameter int DEPTH     = 16,
    parameter int SEQ_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [INST_SIZE-1:0]   wb_inst,
    input  logic [REG_W-1:0]       wb_reg,
    input  logic [WORD-1:0]        wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SEQ_W-1:0]       out_seq,
    output logic [INST_SIZE-1:0]   out_inst,
    output logic [REG_W-1:0]       out_reg,
    output logic [WORD-1:0]        out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [SEQ_W-1:0]       drop_cnt,
    input  logic                   match_en,
    input  logic [WORD-1:0]        match_value,
    output logic                   match_hit
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_LVL_W  = c_ADDR_W + 1;
    localparam int c_REC_W  = SEQ_W + INST_SIZE + REG_W + WORD;
    localparam logic [c_LVL_W-1:0] c_FULL_LEVEL = c_LVL_W'(DEPTH);

    logic [c_REC_W-1:0]  r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic [SEQ_W-1:0]    r_seq;
    logic [SEQ_W-1:0]    r_drop_cnt;
    logic                r_overflow;
    logic                r_match_hit;

    logic                w_accept;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;
    logic [c_REC_W-1:0]  w_head;

`ifdef WB_TRACE_XZR_FILTER_EN
    // XZR writes are architecturally invisible, so they never reach the trace
    assign w_accept = wb_valid && (wb_reg != REG_W'(31));
`else
    assign w_accept = wb_valid;
`endif

    assign w_full  = (r_level == c_FULL_LEVEL);
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still accept
    assign w_push  = w_accept && (!w_full || w_pop);
    assign w_drop  = w_accept && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_seq, wb_inst, wb_reg, wb_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_seq       <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_match_hit <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // Sequence advances on dropped records too, leaving visible gaps
            if (w_accept) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + SEQ_W'(1);
                end
            end
            r_match_hit <= w_accept && match_en && (wb_data == match_value);
        end
    end

    assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

    assign out_valid = !w_empty;
    assign {out_seq, out_inst, out_reg, out_data} = w_head;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
    assign match_hit = r_match_hit;

endmodule

`default_nettype wire
